mult_share_arbiter: RTL and testbench

Round-robin controller that shares one sequential radix-4 Booth multiplier core between `NREQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and issues a one-cycle start to the core. It waits for the core's done strobe, then returns the registered `2N`-bit product to the owning requester over a one-hot valid/ready response channel. It sits between the requesting datapath units and the multiplier core with its operand/result registers.

---
 rtl/mult_share_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one sequential (radix-4 Booth) multiplier core between NREQ
// requesters. One operand pair is accepted at a time and passed to the core
// with a one-cycle start pulse. When the core signals done, the registered
// 2N-bit product goes back to the requester that owns the transaction.
//
// Requesters are arbitrated round-robin. The search starts one past the last
// served requester.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort a BUSY phase that
// runs TIMEOUT cycles without mul_done. An aborted transaction returns
// result 0 with resp_err=1. Without the macro, BUSY waits indefinitely and
// resp_err is tied low.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    [NREQ]     request valid per requester
//   req_a/req_b  [NREQ*N]   operands; requester i at [i*N +: N]
//   req_ready    [NREQ]     one-hot grant (combinational, IDLE only)
//   resp_valid   [NREQ]     one-hot response valid for the owner
//   resp_ready   [NREQ]     response accept per requester
//   resp_result  [2N]       signed product
//   resp_err                abort flag, qualified by resp_valid
//   mul_a/mul_b  [N]        operands to the core, held from ISSUE onwards
//   mul_start               one-cycle start pulse to the core
//   mul_done                core done strobe, sampled only in BUSY
//   mul_product  [2N]       core product, valid with mul_done
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int N       = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_a,
    input  logic [NREQ*N-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     resp_valid,
    input  logic [NREQ-1:0]     resp_ready,
    output logic [2*N-1:0]      resp_result,
    output logic                resp_err,
    output logic [N-1:0]        mul_a,
    output logic [N-1:0]        mul_b,
    output logic                mul_start,
    input  logic                mul_done,
    input  logic [2*N-1:0]      mul_product
);

    localparam int IW = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [IW-1:0]     r_last;
    logic [IW-1:0]     r_owner;
    logic [N-1:0]      r_mul_a;
    logic [N-1:0]      r_mul_b;
    logic              r_mul_start;
    logic [2*N-1:0]    r_result;
    logic [NREQ-1:0]   r_resp_valid;

    logic [IW-1:0]     w_cand [NREQ];
    logic [IW-1:0]     w_winner;
    logic              w_found;
    logic              w_timeout;

    // ------------------------------------------------------------------
    // Round-robin candidate order. Slot gi holds requester (last+1+gi) mod
    // NREQ. The sum never exceeds 2*NREQ-1, so one conditional subtract
    // is enough and NREQ does not need to be a power of two.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rr
            logic [IW:0] w_sum;
            assign w_sum = {1'b0, r_last} + (IW+1)'(gi + 1);
            assign w_cand[gi] = (w_sum >= (IW+1)'(NREQ)) ?
                                IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];
        end
    endgenerate

    // The lowest slot with a valid request wins. The loop runs downwards,
    // so the lowest slot is the last one to write the result.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[k];
            end
        end
    end

    // The grant is only visible in IDLE. It is forced low while reset is
    // asserted, because the state register already reads IDLE during reset.
    assign req_ready = (reset && (r_state == S_IDLE) && w_found) ?
                       (ONE_HOT0 << w_winner) : '0;

    // ------------------------------------------------------------------
    // Optional BUSY watchdog
    // ------------------------------------------------------------------
`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_tmo_cnt;
    logic          r_err;

    // The abort fires in the BUSY cycle whose increment would bring the
    // count to TIMEOUT. A mul_done in that same cycle still wins.
    assign w_timeout = (r_state == S_BUSY) &&
                       ((r_tmo_cnt + CW'(1)) == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_tmo_cnt <= r_tmo_cnt + CW'(1);
            end
            if (r_state == S_BUSY) begin
                if (mul_done) begin
                    r_err <= 1'b0;
                end else if (w_timeout) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign resp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found)                 w_state_next = S_ISSUE;
            S_ISSUE:                              w_state_next = S_BUSY;
            S_BUSY:  if (mul_done || w_timeout)   w_state_next = S_RESP;
            S_RESP:  if (resp_ready[r_owner])     w_state_next = S_IDLE;
            default:                              w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last       <= IW'(NREQ - 1);
            r_owner      <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_start  <= 1'b0;
            r_result     <= '0;
            r_resp_valid <= '0;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The winner's request transfers in this cycle.
                    if (w_found) begin
                        r_mul_a     <= req_a[w_winner*N +: N];
                        r_mul_b     <= req_b[w_winner*N +: N];
                        r_owner     <= w_winner;
                        r_mul_start <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (mul_done) begin
                        r_result     <= mul_product;
                        r_resp_valid <= ONE_HOT0 << r_owner;
                    end else if (w_timeout) begin
                        r_result     <= '0;
                        r_resp_valid <= ONE_HOT0 << r_owner;
                    end
                end
                S_RESP: begin
                    if (resp_ready[r_owner]) begin
                        r_resp_valid <= '0;
                        r_last       <= r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign mul_start   = r_mul_start;
    assign resp_result = r_result;
    assign resp_valid  = r_resp_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int N       = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;
    localparam int W2      = 2 * N;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*N-1:0]   req_a;
    logic [NREQ*N-1:0]   req_b;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     resp_valid;
    logic [NREQ-1:0]     resp_ready;
    logic [W2-1:0]       resp_result;
    logic                resp_err;
    logic [N-1:0]        mul_a;
    logic [N-1:0]        mul_b;
    logic                mul_start;
    logic                mul_done;
    logic [W2-1:0]       mul_product;

    mult_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_result(resp_result),
        .resp_err   (resp_err),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             owner;
        logic [W2-1:0]  res;
        logic           err;
    } exp_t;

    exp_t sb_q[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   core_lat = 3;   // 0 = core never raises done
    bit   tmo_mode = 1'b0;

    task automatic check_value(input string tag, input logic [W2-1:0] obs,
                               input logic [W2-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W2-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [W2-1:0] sa;
        logic signed [W2-1:0] sb;
        sa = {{N{a[N-1]}}, a};
        sb = {{N{b[N-1]}}, b};
        return sa * sb;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Multiplier core model: done arrives core_lat cycles after the start
    // cycle, with the product of the operands seen at start.
    initial begin
        int cnt;
        cnt = 0;
        mul_done = 1'b0;
        mul_product = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cnt = 0;
                mul_done = 1'b0;
            end else begin
                mul_done = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) mul_done = 1'b1;
                end
                if (mul_start && core_lat > 0) begin
                    cnt = core_lat;
                    mul_product = smul(mul_a, mul_b);
                end
            end
        end
    end

    // Monitor: push expectations on grant, pop on response handshake.
    initial begin
        bit             hold;
        logic [W2-1:0]  prev_res;
        logic [NREQ-1:0] prev_vld;
        logic [NREQ-1:0] gnt;
        exp_t           e;
        hold = 1'b0;
        prev_res = '0;
        prev_vld = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                gnt = req_valid & req_ready;
                if (gnt != '0) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (gnt[i]) begin
                            e.owner = i;
                            if (tmo_mode) begin
                                e.res = '0;
                                e.err = 1'b1;
                            end else begin
                                e.res = smul(req_a[i*N +: N], req_b[i*N +: N]);
                                e.err = 1'b0;
                            end
                            sb_q.push_back(e);
                            grant_log.push_back(i);
                            $display("GRANT requester=%0d t=%0t", i, $time);
                        end
                    end
                end
                if (resp_valid != '0) begin
                    if (hold) begin
                        check_value("hold_valid", W2'(resp_valid), W2'(prev_vld));
                        check_value("hold_result", resp_result, prev_res);
                    end
                    if (sb_q.size() == 0) begin
                        check_value("unexpected_resp", W2'(resp_valid), '0);
                        hold = 1'b0;
                    end else if ((resp_valid & resp_ready) != '0) begin
                        e = sb_q.pop_front();
                        check_value("resp_owner", W2'(resp_valid), W2'(onehot(e.owner)));
                        check_value("resp_result", resp_result, e.res);
                        check_value("resp_err", W2'(resp_err), W2'(e.err));
                        $display("RESP owner=%0d result=0x%0h err=%0b", e.owner, resp_result, resp_err);
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        prev_res = resp_result;
                        prev_vld = resp_valid;
                    end
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || resp_valid != '0) && n < 300) begin
            step();
            n++;
        end
        check_value("drain", W2'(n < 300), W2'(1));
    endtask

    // Issue one request from an idle DUT; return once resp_valid is up.
    task automatic run_one(input int idx, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int lat, input int exp_lat);
        int n;
        core_lat = lat;
        req_a[idx*N +: N] = a;
        req_b[idx*N +: N] = b;
        req_valid = onehot(idx);
        #1;
        check_value("grant", W2'(req_ready), W2'(onehot(idx)));
        step();
        req_valid = '0;
        check_value("mul_start", W2'(mul_start), W2'(1));
        check_value("mul_a", W2'(mul_a), W2'(a));
        check_value("mul_b", W2'(mul_b), W2'(b));
        n = 0;
        while (resp_valid == '0 && n < 200) begin
            step();
            n++;
            if (n == 1) check_value("mul_start_pulse", W2'(mul_start), '0);
        end
        check_value("latency", W2'(n), W2'(exp_lat));
    endtask

    initial begin
        int n;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;
        reset      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_req_ready", W2'(req_ready), '0);
        check_value("rst_resp_valid", W2'(resp_valid), '0);
        check_value("rst_result", resp_result, '0);
        check_value("rst_err", W2'(resp_err), '0);
        check_value("rst_mul_a", W2'(mul_a), '0);
        check_value("rst_mul_b", W2'(mul_b), '0);
        check_value("rst_mul_start", W2'(mul_start), '0);
        req_valid = '0;
        reset = 1'b1;
        step();

        // Fairness with every requester continuously valid.
        core_lat = 2;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = N'(i + 3);
            req_b[i*N +: N] = N'(100 - i);
        end
        grant_log.delete();
        req_valid = '1;
        n = 0;
        while (grant_log.size() < 6 && n < 300) begin
            step();
            n++;
        end
        req_valid = '0;
        check_value("rr_count", W2'(grant_log.size()), W2'(6));
        if (grant_log.size() >= 6) begin
            for (int i = 0; i < 6; i++)
                check_value($sformatf("rr_order%0d", i), W2'(grant_log[i]), W2'(i % NREQ));
        end
        wait_drain();

        // Single multiply: requester 2, 7 * -3, done three cycles after start.
        run_one(2, 32'd7, -32'sd3, 3, 4);
        check_value("single_result", resp_result, -64'sd21);
        check_value("single_valid", W2'(resp_valid), W2'(4'b0100));
        wait_drain();

        // Minimum latency and width extremes.
        run_one(0, 32'h8000_0000, 32'h8000_0000, 1, 2);
        check_value("ext_min_neg", resp_result, 64'h4000_0000_0000_0000);
        wait_drain();
        run_one(1, 32'hFFFF_FFFF, 32'd1, 2, 3);
        check_value("ext_all_ones", resp_result, {W2{1'b1}});
        wait_drain();

        // Response backpressure; non-owner ready bits asserted but ignored.
        core_lat = 2;
        resp_ready = 4'b1101;
        req_a[1*N +: N] = 32'd1234;
        req_b[1*N +: N] = -32'sd77;
        req_a[3*N +: N] = 32'd9;
        req_b[3*N +: N] = 32'd11;
        req_valid = 4'b0010;
        #1;
        check_value("bp_grant", W2'(req_ready), W2'(4'b0010));
        step();
        req_valid = 4'b1010;
        n = 0;
        while (resp_valid == '0 && n < 100) begin
            step();
            n++;
        end
        check_value("bp_valid", W2'(resp_valid), W2'(4'b0010));
        repeat (10) begin
            step();
            check_value("bp_hold_valid", W2'(resp_valid), W2'(4'b0010));
            check_value("bp_no_grant", W2'(req_ready), '0);
        end
        resp_ready = '1;
        step();
        check_value("bp_next_grant", W2'(req_ready), W2'(4'b1000));
        step();
        req_valid = '0;
        wait_drain();

        // Reset while BUSY: discard the transaction, then 0 beats 3.
        core_lat = 0;
        req_a[0] = 1'b1;
        req_valid = 4'b0001;
        #1;
        check_value("rb_grant", W2'(req_ready), W2'(4'b0001));
        step();
        req_valid = '0;
        repeat (4) step();
        check_value("rb_busy_no_resp", W2'(resp_valid), '0);
        req_valid = 4'b1001;
        reset = 1'b0;
        #1;
        sb_q.delete();
        check_value("rb_req_ready", W2'(req_ready), '0);
        check_value("rb_resp_valid", W2'(resp_valid), '0);
        check_value("rb_mul_start", W2'(mul_start), '0);
        check_value("rb_mul_a", W2'(mul_a), '0);
        check_value("rb_mul_b", W2'(mul_b), '0);
        check_value("rb_result", resp_result, '0);
        core_lat = 2;
        repeat (2) step();
        check_value("rb_still_quiet", W2'(resp_valid), '0);
        reset = 1'b1;
        #1;
        check_value("rb_prio0", W2'(req_ready), W2'(4'b0001));
        step();
        req_valid = '0;
        wait_drain();

`ifdef MULT_ARB_TIMEOUT_EN
        // Withheld done aborts after TIMEOUT BUSY cycles.
        tmo_mode = 1'b1;
        run_one(2, 32'd5, 32'd6, 0, TIMEOUT + 1);
        check_value("tmo_err", W2'(resp_err), W2'(1));
        check_value("tmo_result", resp_result, '0);
        wait_drain();
        // Done in the TIMEOUT-th cycle wins over the abort.
        tmo_mode = 1'b0;
        run_one(3, 32'd5, 32'd6, TIMEOUT, TIMEOUT + 1);
        check_value("tmo_edge_err", W2'(resp_err), '0);
        check_value("tmo_edge_result", resp_result, W2'(30));
        wait_drain();
        // Done one cycle too late is ignored.
        tmo_mode = 1'b1;
        run_one(0, 32'd5, 32'd6, TIMEOUT + 1, TIMEOUT + 1);
        check_value("tmo_late_err", W2'(resp_err), W2'(1));
        wait_drain();
        tmo_mode = 1'b0;
`else
        // Without the watchdog a slow core is simply waited for.
        run_one(2, -32'sd9, -32'sd9, 20, 21);
        check_value("slow_result", resp_result, W2'(81));
        check_value("slow_err", W2'(resp_err), '0);
        wait_drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

endmodule
